// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI front end: default port addresses, FSM and
// transfer-kind encodings, and the status byte layout.
package sd_pkg;

  localparam logic [7:0] CTRL_PORT_DEF    = 8'hE7;
  localparam logic [7:0] DATA_PORT_DEF    = 8'hEB;
  localparam logic [2:0] RISE_TIMEOUT_DEF = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_WAIT_RISE,
    ST_WAIT_FALL
  } state_t;

  typedef enum logic {
    KIND_TX,
    KIND_RX
  } kind_t;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;
  localparam int STAT_CS_LO   = 2;

  function automatic logic [7:0] status_byte(input logic [1:0] cs_n,
                                             input logic       overrun,
                                             input logic       busy);
    logic [7:0] s;
    s                   = '0;
    s[STAT_BUSY]        = busy;
    s[STAT_OVERRUN]     = overrun;
    s[STAT_CS_LO +: 2]  = cs_n;
    return s;
  endfunction

endpackage

// File: rtl/spi_port_ctrl.sv
// Z80 port front end for the SD-card SPI byte engine: one-byte queue, strobe sequencing,
// chip-select ownership and a status port.
module spi_port_ctrl
  import sd_pkg::*;
#(
  parameter logic [7:0] CTRL_PORT    = CTRL_PORT_DEF,
  parameter logic [7:0] DATA_PORT    = DATA_PORT_DEF,
  parameter logic [2:0] RISE_TIMEOUT = RISE_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_din,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic       cpu_m1_n,
  output logic [7:0] cpu_dout,
  output logic       cpu_oe,
  output logic       spi_tx_strobe,
  output logic       spi_rx_strobe,
  output logic [7:0] spi_din,
  input  logic [7:0] spi_dout,
  input  logic       spi_transmit,
  output logic [1:0] sd_cs_n
);

  logic       ctrl_hit, data_hit, port_hit;
  logic       io_act, io_act_q, io_ev, is_wr;
  logic       data_wr_ev, data_rd_ev, data_ev, ctrl_wr_ev, ctrl_rd_ev;

  state_t     state_q, state_d;
  logic       launch, timeout_hit, drop;
  logic [2:0] timer;

  logic       pend_valid;
  kind_t      pend_kind;
  logic [7:0] pend_byte;

  logic       overrun, busy;
  logic       cs_req;
  logic [1:0] cs_next;
  logic [7:0] status_live, status_snap;

  assign ctrl_hit = (cpu_addr == CTRL_PORT);
  assign data_hit = (cpu_addr == DATA_PORT);
  assign port_hit = ctrl_hit | data_hit;

  // Interrupt-acknowledge cycles (M1 low) also assert IORQ and must never decode.
  assign io_act = ~cpu_iorq_n & cpu_m1_n & (~cpu_rd_n | ~cpu_wr_n) & port_hit;
  assign io_ev  = io_act & ~io_act_q;
  assign is_wr  = ~cpu_wr_n & cpu_rd_n;

  assign data_wr_ev = io_ev & data_hit & is_wr;
  assign data_rd_ev = io_ev & data_hit & ~cpu_rd_n;
  assign data_ev    = data_wr_ev | data_rd_ev;
  assign ctrl_wr_ev = io_ev & ctrl_hit & is_wr;
  assign ctrl_rd_ev = io_ev & ctrl_hit & ~cpu_rd_n;

  // A draining buffer counts as empty, so an event in the launch cycle is kept.
  assign drop = data_ev & pend_valid & ~launch;

  assign busy        = (state_q != ST_IDLE) | pend_valid;
  assign status_live = status_byte(sd_cs_n, overrun, busy);

  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
    state_d     = state_q;
    launch      = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_valid && !spi_transmit) begin
          launch  = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE:    state_d = ST_WAIT_RISE;
      ST_WAIT_RISE: begin
        if (spi_transmit) begin
          state_d = ST_WAIT_FALL;
        end else if (timer == RISE_TIMEOUT) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_WAIT_FALL: begin
        if (!spi_transmit) state_d = ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_act_q      <= 1'b0;
      timer         <= '0;
      pend_valid    <= 1'b0;
      pend_kind     <= KIND_TX;
      pend_byte     <= 8'hFF;
      spi_tx_strobe <= 1'b0;
      spi_rx_strobe <= 1'b0;
      spi_din       <= 8'hFF;
      overrun       <= 1'b0;
      cs_req        <= 1'b0;
      cs_next       <= 2'b11;
      sd_cs_n       <= 2'b11;
      status_snap   <= 8'h00;
    end else begin
      io_act_q <= io_act;
      timer    <= (state_q == ST_WAIT_RISE) ? timer + 3'd1 : 3'd0;

      // NOTE: non-blocking throughout; where two statements below assign the same
      // register in one cycle, the later one wins, which sets the intended priority.
      if (launch) pend_valid <= 1'b0;
      if (data_ev && !drop) begin
        pend_valid <= 1'b1;
        pend_kind  <= data_wr_ev ? KIND_TX : KIND_RX;
        pend_byte  <= data_wr_ev ? cpu_din : 8'hFF;
      end

      spi_tx_strobe <= launch & (pend_kind == KIND_TX);
      spi_rx_strobe <= launch & (pend_kind == KIND_RX);
      if (launch) spi_din <= pend_byte;

      if (drop || timeout_hit) overrun <= 1'b1;
      else if (ctrl_rd_ev)     overrun <= 1'b0;

      // Chip selects only move between bytes; a newer write overrides an unapplied one.
      if (cs_req && state_q == ST_IDLE && !pend_valid) begin
        sd_cs_n <= cs_next;
        cs_req  <= 1'b0;
      end
      if (ctrl_wr_ev) begin
        cs_next <= cpu_din[1:0];
        cs_req  <= 1'b1;
      end

      // Frozen for the rest of an access so the CPU sees the pre-clear overrun bit.
      if (!io_act_q) status_snap <= status_live;
    end
  end

  assign cpu_oe = ~cpu_iorq_n & cpu_m1_n & ~cpu_rd_n & port_hit;

  always_comb begin
    cpu_dout = 8'h00;
    if (cpu_oe) begin
      if (data_hit)      cpu_dout = spi_dout;
      else if (io_act_q) cpu_dout = status_snap;
      else               cpu_dout = status_live;
    end
  end

endmodule
